// File: rtl/up_down_counter_pkg.sv
// Shared types for the loadable up/down counter: default width, operation enum and priority decode.
// Build option UP_DOWN_COUNTER_WRAP_EN (see udc_next_calc) switches saturation to wrap-around.
package up_down_counter_pkg;

  localparam int UDC_WIDTH = 5;

  typedef enum logic [1:0] {
    OP_HOLD,
    OP_LOAD,
    OP_DEC,
    OP_INC
  } udc_op_e;

  // Load beats down, down beats up; a simultaneous down+up is a plain decrement.
  function automatic udc_op_e udc_decode(input logic load, input logic down, input logic up);
    udc_op_e op;
    op = OP_HOLD;
    if (load) begin
      op = OP_LOAD;
    end else if (down) begin
      op = OP_DEC;
    end else if (up) begin
      op = OP_INC;
    end
    return op;
  endfunction

endpackage

// File: rtl/up_down_counter_if.sv
// Request/status bundle of the up/down counter; master drives requests, slave returns the count.
// Unaffected by UP_DOWN_COUNTER_WRAP_EN.
interface up_down_counter_if
  import up_down_counter_pkg::*;
#(
  parameter int WIDTH = UDC_WIDTH
);

  logic [WIDTH-1:0] in;
  logic             load;
  logic             down;
  logic             up;
  logic [WIDTH-1:0] counter;
  logic             low;
  logic             high;

  modport master (
    output in, load, down, up,
    input  counter, low, high
  );

  modport slave (
    input  in, load, down, up,
    output counter, low, high
  );

endinterface

// File: rtl/udc_next_calc.sv
// Next-count datapath of the up/down counter; saturates at 0 and max by default,
// wraps around instead when UP_DOWN_COUNTER_WRAP_EN is defined.
module udc_next_calc
  import up_down_counter_pkg::*;
#(
  parameter int WIDTH = UDC_WIDTH
) (
  input  udc_op_e          op,
  input  logic [WIDTH-1:0] counter,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] next
);

  localparam logic [WIDTH-1:0] MAX_VAL = '1;
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

  always_comb begin
    next = counter;
    unique case (op)
      OP_LOAD: next = in;
`ifdef UP_DOWN_COUNTER_WRAP_EN
      OP_DEC:  next = counter - ONE;
      OP_INC:  next = counter + ONE;
`else
      // Bounds pin the count instead of letting the subtraction/addition roll over.
      OP_DEC:  next = (counter == '0) ? counter : counter - ONE;
      OP_INC:  next = (counter == MAX_VAL) ? counter : counter + ONE;
`endif
      default: next = counter;
    endcase
  end

endmodule

// File: rtl/up_down_counter.sv
// Loadable up/down counter with low/high bound flags and synchronous active-high reset.
// Define UP_DOWN_COUNTER_WRAP_EN for wrap-around instead of saturation.
module up_down_counter
  import up_down_counter_pkg::*;
#(
  parameter int WIDTH = UDC_WIDTH
) (
  input  logic              clk,
  input  logic              rst,
  up_down_counter_if.slave  bus
);

  localparam logic [WIDTH-1:0] MAX_VAL = '1;

  udc_op_e          op;
  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_next;

  assign op = udc_decode(bus.load, bus.down, bus.up);

  udc_next_calc #(
    .WIDTH (WIDTH)
  ) u_next_calc (
    .op      (op),
    .counter (count_q),
    .in      (bus.in),
    .next    (count_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_next;
    end
  end

  // Flags decode the register directly so they line up with the visible count.
  assign bus.counter = count_q;
  assign bus.low     = (count_q == '0);
  assign bus.high    = (count_q == MAX_VAL);

endmodule

// File: tb/tb_up_down_counter.sv
// Self-checking bench for up_down_counter: directed scenarios then random traffic against an integer model.
// Follows UP_DOWN_COUNTER_WRAP_EN to choose saturating or wrapping expectations.
module tb_up_down_counter;
  import up_down_counter_pkg::*;

  localparam int W    = UDC_WIDTH;
  localparam int MAXV = (1 << W) - 1;

  logic clk;
  logic rst;
  int   errors;
  int   checks;
  int   model;

  up_down_counter_if #(.WIDTH(W)) bus ();

  up_down_counter #(
    .WIDTH (W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model counts in plain integers and applies the rules directly; inputs change #1 after the edge.
  task automatic applyStimulus(input logic r, input int v, input logic l, input logic d, input logic u);
    rst      = r;
    bus.in   = W'(v);
    bus.load = l;
    bus.down = d;
    bus.up   = u;
    if (r) begin
      model = 0;
    end else if (l) begin
      model = v;
    end else if (d) begin
`ifdef UP_DOWN_COUNTER_WRAP_EN
      model = (model + MAXV) % (MAXV + 1);
`else
      model = (model > 0) ? model - 1 : 0;
`endif
    end else if (u) begin
`ifdef UP_DOWN_COUNTER_WRAP_EN
      model = (model + 1) % (MAXV + 1);
`else
      model = (model < MAXV) ? model + 1 : MAXV;
`endif
    end
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag);
    int got;
    got = int'(bus.counter);
    checks++;
    assert (got === model) else begin
      errors++;
      $error("[TB] FAIL %s counter got=%0d expected=%0d", tag, got, model);
    end
    checks++;
    assert (bus.low === (model == 0)) else begin
      errors++;
      $error("[TB] FAIL %s low got=%b expected=%b", tag, bus.low, (model == 0));
    end
    checks++;
    assert (bus.high === (model == MAXV)) else begin
      errors++;
      $error("[TB] FAIL %s high got=%b expected=%b", tag, bus.high, (model == MAXV));
    end
  endtask

  task automatic checkValue(input string tag, input int expected);
    int got;
    got = int'(bus.counter);
    checks++;
    assert (got === expected) else begin
      errors++;
      $error("[TB] FAIL %s counter got=%0d expected=%0d", tag, got, expected);
    end
  endtask

  initial begin
    logic r, l, d, u;
    int   v;
    errors   = 0;
    checks   = 0;
    model    = 0;
    rst      = 1'b0;
    bus.in   = '0;
    bus.load = 1'b0;
    bus.down = 1'b0;
    bus.up   = 1'b0;
    #2;

    applyStimulus(1'b1, 0, 1'b0, 1'b0, 1'b0);
    checkOutput("reset");
    checkValue("reset_const", 0);

    applyStimulus(1'b0, 7, 1'b1, 1'b0, 1'b0);
    checkOutput("load7");
    checkValue("load7_const", 7);
    applyStimulus(1'b0, 0, 1'b0, 1'b1, 1'b0);
    checkValue("down_to6", 6);
    applyStimulus(1'b0, 0, 1'b0, 1'b0, 1'b1);
    checkValue("up_to7", 7);
    applyStimulus(1'b0, 0, 1'b0, 1'b1, 1'b1);
    checkOutput("down_beats_up");
    checkValue("down_beats_up_const", 6);
    applyStimulus(1'b0, 0, 1'b0, 1'b0, 1'b0);
    checkValue("hold6", 6);

    for (int i = 0; i < 7; i++) begin
      applyStimulus(1'b0, 0, 1'b0, 1'b1, 1'b0);
      checkOutput("down_run");
    end
`ifdef UP_DOWN_COUNTER_WRAP_EN
    checkValue("low_wrap", MAXV);
`else
    checkValue("low_sat", 0);
`endif
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b0, 0, 1'b0, 1'b1, 1'b0);
      checkOutput("down_extra");
    end

    applyStimulus(1'b0, 0, 1'b1, 1'b0, 1'b0);
    checkValue("load0", 0);
    for (int i = 0; i < 32; i++) begin
      applyStimulus(1'b0, 0, 1'b0, 1'b0, 1'b1);
      checkOutput("up_run");
      if (i == 30) checkValue("reach_max", MAXV);
    end
`ifdef UP_DOWN_COUNTER_WRAP_EN
    checkValue("high_wrap", 0);
`else
    checkValue("high_sat", MAXV);
`endif

    applyStimulus(1'b0, MAXV, 1'b1, 1'b0, 1'b0);
    checkOutput("load_max");
    applyStimulus(1'b0, 3, 1'b1, 1'b0, 1'b1);
    checkValue("load_over_up", 3);
    applyStimulus(1'b1, 9, 1'b1, 1'b1, 1'b1);
    checkOutput("rst_over_load");
    checkValue("rst_over_load_const", 0);

    // Alternate down-heavy and up-heavy stretches so both bounds are visited repeatedly.
    for (int i = 0; i < 400; i++) begin
      r = ($urandom_range(0, 59) == 0);
      l = ($urandom_range(0, 14) == 0);
      v = int'($urandom_range(0, MAXV));
      if (((i / 50) % 2) == 0) begin
        d = ($urandom_range(0, 3) != 0);
        u = ($urandom_range(0, 1) == 0);
      end else begin
        d = ($urandom_range(0, 5) == 0);
        u = ($urandom_range(0, 4) != 0);
      end
      applyStimulus(r, v, l, d, u);
      checkOutput("random");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
